// File: rtl/param_stopwatch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_stopwatch_if : control inputs and display/status outputs of the stopwatch
// Revision 1.0
// ---------------------------------------------------------------------------
interface param_stopwatch_if #(
  parameter int DIGITS = 4
) ();
  logic                  run;
  logic                  clear;
  logic                  count_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  lap;
  logic [4*DIGITS-1:0]   count_value;
  logic [7*DIGITS-1:0]   seg;
  logic                  running;
  logic                  terminal;
  logic                  lap_active;

  modport master (
    output run, clear, count_down, load, load_value, lap,
    input  count_value, seg, running, terminal, lap_active
  );

  modport slave (
    input  run, clear, count_down, load, load_value, lap,
    output count_value, seg, running, terminal, lap_active
  );
endinterface
`default_nettype wire

// File: rtl/param_stopwatch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_stopwatch : N-digit up/down hex/decimal stopwatch with load, lap hold and 7-seg drive
// Revision 1.0
// ---------------------------------------------------------------------------
module param_stopwatch #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 50000000,
  parameter int RADIX          = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  param_stopwatch_if.slave bus
);
  localparam int          CW        = 4 * DIGITS;
  localparam logic [3:0]  DIG_MAX   = 4'(RADIX - 1);
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  count, count_nx;
  logic [CW-1:0]  snap, snap_nx;
  logic [31:0]    tick, tick_nx;
  logic           lap_on, lap_on_nx;
  logic [CW-1:0]  count_up, count_dn, stepped, load_sat, display;
  logic [7*DIGITS-1:0] seg_r;
  logic           step, at_limit, stepped_at_limit;

  function automatic logic is_limit(input logic [CW-1:0] v, input logic down);
    logic lim;
    lim = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != (down ? 4'd0 : DIG_MAX)) lim = 1'b0;
    end
    return lim;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  // Both directions are precomputed as a digit-wise ripple; count_down selects one.
  always_comb begin
    logic carry, borrow;
    carry    = 1'b1;
    borrow   = 1'b1;
    count_up = count;
    count_dn = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == DIG_MAX) begin
          count_up[4*i +: 4] = 4'd0;
        end else begin
          count_up[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dn[4*i +: 4] = DIG_MAX;
        end else begin
          count_dn[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_sat = bus.load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_value[4*i +: 4] > DIG_MAX) load_sat[4*i +: 4] = DIG_MAX;
    end
  end

  assign stepped          = bus.count_down ? count_dn : count_up;
  assign step             = (tick == TICK_LAST);
  assign at_limit         = is_limit(count, bus.count_down);
  assign stepped_at_limit = is_limit(stepped, bus.count_down);
  assign display          = lap_on ? snap : count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      snap   <= '0;
      tick   <= '0;
      lap_on <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      snap   <= snap_nx;
      tick   <= tick_nx;
      lap_on <= lap_on_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    snap_nx   = snap;
    tick_nx   = tick;
    lap_on_nx = lap_on;
    if (bus.clear) begin
      state_nx  = ST_IDLE;
      count_nx  = '0;
      snap_nx   = '0;
      tick_nx   = '0;
      lap_on_nx = 1'b0;
    end else if (bus.load) begin
      state_nx  = ST_IDLE;
      count_nx  = load_sat;
      tick_nx   = '0;
      lap_on_nx = 1'b0;
    end else begin
      // Lap only touches the display path, so the count keeps going underneath.
      if (bus.lap) begin
        lap_on_nx = ~lap_on;
        if (!lap_on) snap_nx = count;
      end
      case (state)
        ST_IDLE:   if (bus.run) state_nx = ST_RUN;
        ST_PAUSED: if (bus.run) state_nx = ST_RUN;
        ST_RUN: begin
          tick_nx = step ? 32'd0 : tick + 32'd1;
          if (step && at_limit) begin
            state_nx = ST_DONE;
          end else if (step && stepped_at_limit) begin
            count_nx = stepped;
            state_nx = ST_DONE;
          end else begin
            if (step) count_nx = stepped;
            if (!bus.run) state_nx = ST_PAUSED;
          end
        end
        ST_DONE:   state_nx = ST_DONE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGITS; i++) seg_r[7*i +: 7] <= seg_encode(4'h0);
    end else begin
      for (int i = 0; i < DIGITS; i++) seg_r[7*i +: 7] <= seg_encode(display[4*i +: 4]);
    end
  end

  assign bus.count_value = count;
  assign bus.seg         = seg_r;
  assign bus.running     = (state == ST_RUN);
  assign bus.terminal    = (state == ST_DONE);
  assign bus.lap_active  = lap_on;
endmodule
`default_nettype wire

// File: tb/tb_param_stopwatch.sv
`default_nettype none
// tb_param_stopwatch : hex/active-low and decimal/active-high builds driven by shared stimulus,
// compared every cycle against an integer-valued stopwatch model.
module tb_param_stopwatch;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, clear = 1'b0, count_down = 1'b0, load = 1'b0, lap = 1'b0;
  logic [15:0] load_value = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  param_stopwatch_if #(.DIGITS(DIGITS)) bus_h ();
  param_stopwatch_if #(.DIGITS(DIGITS)) bus_d ();

  assign bus_h.run = run;               assign bus_d.run = run;
  assign bus_h.clear = clear;           assign bus_d.clear = clear;
  assign bus_h.count_down = count_down; assign bus_d.count_down = count_down;
  assign bus_h.load = load;             assign bus_d.load = load;
  assign bus_h.load_value = load_value; assign bus_d.load_value = load_value;
  assign bus_h.lap = lap;               assign bus_d.lap = lap;

  param_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .RADIX(16), .SEG_ACTIVE_LOW(1)) dut_h (
    .clock(clk), .reset_n(rst_n), .bus(bus_h.slave));
  param_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .RADIX(10), .SEG_ACTIVE_LOW(0)) dut_d (
    .clock(clk), .reset_n(rst_n), .bus(bus_d.slave));

  // Model: index 0 = hex build, 1 = decimal build. Count held as a plain integer.
  int          m_state [2];   // 0 idle, 1 run, 2 paused, 3 done
  int unsigned m_val   [2];
  int          m_tick  [2];
  bit          m_lap   [2];
  int unsigned m_snap  [2];
  logic [27:0] m_seg   [2];

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int unsigned radix_of(input int r);
    return (r == 0) ? 16 : 10;
  endfunction

  function automatic int unsigned top_of(input int r);
    int unsigned rr;
    rr = radix_of(r);
    return rr * rr * rr * rr - 1;
  endfunction

  function automatic logic [15:0] to_packed(input int unsigned v, input int r);
    logic [15:0] p;
    int unsigned x;
    x = v;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      p[4*i +: 4] = 4'(x % radix_of(r));
      x = x / radix_of(r);
    end
    return p;
  endfunction

  function automatic int unsigned from_load(input logic [15:0] lv, input int r);
    int unsigned v, mul, d;
    v = 0;
    mul = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > radix_of(r) - 1) d = radix_of(r) - 1;
      v = v + d * mul;
      mul = mul * radix_of(r);
    end
    return v;
  endfunction

  function automatic logic [27:0] seg_of(input int unsigned v, input int r);
    logic [15:0] p;
    logic [27:0] s;
    logic [6:0]  pat;
    p = to_packed(v, r);
    s = '0;
    for (int i = 0; i < 4; i++) begin
      pat = seg_tbl[p[4*i +: 4]];
      if (r == 1) pat = ~pat;
      s[7*i +: 7] = pat;
    end
    return s;
  endfunction

  task automatic model_step();
    for (int r = 0; r < 2; r++) begin
      int unsigned lim;
      bit stp;
      if (!rst_n) begin
        m_state[r] = 0; m_val[r] = 0; m_tick[r] = 0; m_lap[r] = 1'b0; m_snap[r] = 0;
        m_seg[r] = seg_of(0, r);
      end else begin
        m_seg[r] = seg_of(m_lap[r] ? m_snap[r] : m_val[r], r);
        if (clear) begin
          m_state[r] = 0; m_val[r] = 0; m_tick[r] = 0; m_lap[r] = 1'b0; m_snap[r] = 0;
        end else if (load) begin
          m_state[r] = 0; m_val[r] = from_load(load_value, r); m_tick[r] = 0; m_lap[r] = 1'b0;
        end else begin
          if (lap) begin
            if (!m_lap[r]) m_snap[r] = m_val[r];
            m_lap[r] = !m_lap[r];
          end
          if (m_state[r] == 0 || m_state[r] == 2) begin
            if (run) m_state[r] = 1;
          end else if (m_state[r] == 1) begin
            stp = (m_tick[r] == TICK_DIV - 1);
            m_tick[r] = stp ? 0 : m_tick[r] + 1;
            lim = count_down ? 0 : top_of(r);
            if (stp && m_val[r] == lim) begin
              m_state[r] = 3;
            end else begin
              if (stp) m_val[r] = count_down ? m_val[r] - 1 : m_val[r] + 1;
              if (stp && m_val[r] == lim) m_state[r] = 3;
              else if (!run) m_state[r] = 2;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input int r, input logic [15:0] cv, input logic [27:0] sg,
                          input logic rn, input logic tm, input logic la);
    check({tag, " count"},    32'(cv), 32'(to_packed(m_val[r], r)));
    check({tag, " seg"},      32'(sg), 32'(m_seg[r]));
    check({tag, " running"},  32'(rn), 32'(m_state[r] == 1));
    check({tag, " terminal"}, 32'(tm), 32'(m_state[r] == 3));
    check({tag, " lap"},      32'(la), 32'(m_lap[r]));
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      cmp_inst("hex", 0, bus_h.count_value, bus_h.seg, bus_h.running, bus_h.terminal, bus_h.lap_active);
      cmp_inst("dec", 1, bus_d.count_value, bus_d.seg, bus_d.running, bus_d.terminal, bus_d.lap_active);
    end
  end

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load_value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset hex seg", 32'(bus_h.seg), 32'h8102040);
    check("reset dec seg", 32'(bus_d.seg), 32'h7EFDFBF);
    check("reset count",   32'(bus_h.count_value), 32'h0);
    rst_n = 1'b1;

    // Count up 31 steps; one extra cycle for IDLE -> RUN.
    run = 1'b1;
    repeat (125) @(negedge clk);
    check("up hex 0x1F",   32'(bus_h.count_value), 32'h001F);
    check("up dec 31",     32'(bus_d.count_value), 32'h0031);
    run = 1'b0;

    pulse_clear();
    pulse_load(16'hFFFE);
    run = 1'b1;
    repeat (5) @(negedge clk);
    check("hex at FFFF",   32'(bus_h.count_value), 32'hFFFF);
    check("hex terminal",  32'(bus_h.terminal), 32'h1);
    check("dec sat 9999",  32'(bus_d.count_value), 32'h9999);
    check("dec terminal",  32'(bus_d.terminal), 32'h1);
    repeat (20) @(negedge clk);
    check("hex FFFF held", 32'(bus_h.count_value), 32'hFFFF);
    check("hex term held", 32'(bus_h.terminal), 32'h1);
    run = 1'b0;

    pulse_clear();
    count_down = 1'b1;
    pulse_load(16'h0100);
    run = 1'b1;
    repeat (5) @(negedge clk);
    check("down hex 00FF", 32'(bus_h.count_value), 32'h00FF);
    check("down dec 0099", 32'(bus_d.count_value), 32'h0099);
    repeat (1020) @(negedge clk);
    check("down hex zero", 32'(bus_h.count_value), 32'h0000);
    check("down hex term", 32'(bus_h.terminal), 32'h1);
    check("down dec term", 32'(bus_d.terminal), 32'h1);
    run = 1'b0;
    count_down = 1'b0;

    pulse_clear();
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (10) @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("resume no step", 32'(bus_h.count_value), 32'h0000);
    check("resume running", 32'(bus_h.running), 32'h1);
    @(negedge clk);
    check("resume step",    32'(bus_h.count_value), 32'h0001);
    pulse_lap();
    repeat (8) @(negedge clk);
    check("lap live count", 32'(bus_h.count_value), 32'h0003);
    check("lap active",     32'(bus_h.lap_active), 32'h1);
    check("lap hex frozen", 32'(bus_h.seg), 32'h8102079);
    check("lap dec frozen", 32'(bus_d.seg), 32'h7EFDF86);
    pulse_lap();
    @(negedge clk);
    check("lap released",   32'(bus_h.lap_active), 32'h0);
    check("lap hex live",   32'(bus_h.seg), 32'h8102030);
    check("lap dec live",   32'(bus_d.seg), 32'h7EFDFCF);
    #2 rst_n = 1'b0;
    #1;
    check("async count",    32'(bus_h.count_value), 32'h0);
    check("async running",  32'(bus_h.running), 32'h0);
    check("async hex seg",  32'(bus_h.seg), 32'h8102040);
    check("async dec seg",  32'(bus_d.seg), 32'h7EFDFBF);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    load_value = 16'h1234;
    clear = 1'b1;
    load = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    load = 1'b0;
    check("clr>load count", 32'(bus_h.count_value), 32'h0);
    check("clr>load idle",  32'(bus_h.running), 32'h0);
    pulse_load(16'h00A5);
    check("load hex 00A5",  32'(bus_h.count_value), 32'h00A5);
    check("load dec sat",   32'(bus_d.count_value), 32'h0095);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      clear = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 59) == 0);
      lap   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) count_down = ~count_down;
      case ($urandom_range(0, 4))
        0: load_value = 16'h0001;
        1: load_value = 16'hFFFE;
        2: load_value = 16'h9998;
        3: load_value = 16'h0000;
        default: load_value = 16'($urandom);
      endcase
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
